control_unit: RTL and testbench

//  Multi-cycle FSM sequencing data_path: fetch -> decode -> execute (-> mem) per instruction.

---
 rtl/control_unit.sv | 189 ++++++++++++++++++
 tb/tb_control_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// ============================================================================
// control_unit : multi-cycle fetch/decode/execute(/mem) sequencer for data_path
// Revision     : 1.0
// ============================================================================
`default_nettype none

module control_unit #(
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic [31:0] ir,
   input  logic        alu_c,
   input  logic        alu_z,
   output logic        clr_A,
   output logic        clr_B,
   output logic        clr_C,
   output logic        clr_Z,
   output logic        clr_PC,
   output logic        clr_IR,
   output logic        ld_A,
   output logic        ld_B,
   output logic        ld_C,
   output logic        ld_Z,
   output logic        ld_PC,
   output logic        ld_IR,
   output logic        inc_PC,
   output logic [1:0]  data_mux,
   output logic [1:0]  im_mux2,
   output logic        im_mux1,
   output logic        a_mux,
   output logic        b_mux,
   output logic        reg_mux,
   output logic [2:0]  alu_op,
   output logic        wen,
   output logic        en,
   output logic        flag_c,
   output logic        flag_z,
   output logic        halted
);

   localparam logic [2:0] S_RESET  = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   localparam logic [2:0] MEM_LAST = 3'(MEM_LAT - 1);

   logic [2:0] state_q, state_d;
   logic [2:0] mem_cnt_q, mem_cnt_d;
   logic       flag_c_q, flag_c_d;
   logic       flag_z_q, flag_z_d;

   logic [3:0] w_opcode;
   logic       w_is_alu;
   logic       w_mem_last;
   logic       w_unused;

   assign w_opcode   = ir[31:28];
   assign w_is_alu   = (w_opcode >= 4'h6) && (w_opcode <= 4'hA);
   assign w_mem_last = (mem_cnt_q == MEM_LAST);
   // Operand fields are consumed by the datapath, not here.
   assign w_unused   = ^ir[27:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_RESET;
         mem_cnt_q <= 3'd0;
         flag_c_q  <= 1'b0;
         flag_z_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         mem_cnt_q <= mem_cnt_d;
         flag_c_q  <= flag_c_d;
         flag_z_q  <= flag_z_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mem_cnt_d = mem_cnt_q;
      flag_c_d  = flag_c_q;
      flag_z_d  = flag_z_q;
      case (state_q)
         S_RESET:  state_d = S_FETCH;
         S_FETCH:  if (run) state_d = S_DECODE;
         S_DECODE: state_d = (w_opcode == 4'hF) ? S_HALT : S_EXEC;
         S_EXEC: begin
            state_d = ((w_opcode == 4'h2) || (w_opcode == 4'h3)) ? S_MEM : S_FETCH;
            if (w_is_alu) begin
               flag_c_d = alu_c;
               flag_z_d = alu_z;
            end
         end
         S_MEM: begin
            if (w_mem_last) begin
               state_d   = S_FETCH;
               mem_cnt_d = 3'd0;
            end else begin
               mem_cnt_d = mem_cnt_q + 3'd1;
            end
         end
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_RESET;
      endcase
   end

   always_comb begin
      clr_A    = 1'b0;
      clr_B    = 1'b0;
      clr_C    = 1'b0;
      clr_Z    = 1'b0;
      clr_PC   = 1'b0;
      clr_IR   = 1'b0;
      ld_A     = 1'b0;
      ld_B     = 1'b0;
      ld_C     = 1'b0;
      ld_Z     = 1'b0;
      ld_PC    = 1'b0;
      ld_IR    = 1'b0;
      inc_PC   = 1'b0;
      data_mux = 2'b00;
      im_mux2  = 2'b00;
      im_mux1  = 1'b0;
      a_mux    = 1'b0;
      b_mux    = 1'b0;
      reg_mux  = 1'b0;
      alu_op   = 3'b000;
      wen      = 1'b0;
      en       = 1'b0;
      halted   = 1'b0;
      case (state_q)
         S_RESET: begin
            clr_A  = 1'b1;
            clr_B  = 1'b1;
            clr_C  = 1'b1;
            clr_Z  = 1'b1;
            clr_PC = 1'b1;
            clr_IR = 1'b1;
         end
         S_FETCH:  ld_IR  = run;
         // HALT skips the increment so PC keeps pointing at the halt word.
         S_DECODE: inc_PC = (w_opcode != 4'hF);
         S_EXEC: begin
            case (w_opcode)
               4'h0: begin a_mux = 1'b1; ld_A = 1'b1; end
               4'h1: begin b_mux = 1'b1; ld_B = 1'b1; end
               4'h2, 4'h3: en = 1'b1;
               4'h4: begin en = 1'b1; wen = 1'b1; end
               4'h5: begin en = 1'b1; wen = 1'b1; reg_mux = 1'b1; end
               4'h6: alu_op = 3'b010;
               4'h7: alu_op = 3'b110;
               4'h8: alu_op = 3'b000;
               4'h9: alu_op = 3'b001;
               4'hA: begin alu_op = 3'b010; im_mux2 = 2'b01; end
               4'hB: ld_PC = 1'b1;
               4'hC: ld_PC = flag_z_q;
               4'hD: ld_PC = flag_c_q;
               default: ;
            endcase
            if (w_is_alu) begin
               data_mux = 2'b10;
               ld_A     = 1'b1;
               ld_C     = 1'b1;
               ld_Z     = 1'b1;
            end
         end
         S_MEM: begin
            en = 1'b1;
            if (w_mem_last) begin
               data_mux = 2'b01;
               ld_A     = (w_opcode == 4'h2);
               ld_B     = (w_opcode == 4'h3);
            end
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

   assign flag_c = flag_c_q;
   assign flag_z = flag_z_q;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// tb_control_unit : directed program sequences with a per-cycle scoreboard
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_control_unit;

   localparam logic [28:0] HALTED  = 29'd1 << 0;
   localparam logic [28:0] F_Z     = 29'd1 << 1;
   localparam logic [28:0] F_C     = 29'd1 << 2;
   localparam logic [28:0] EN      = 29'd1 << 3;
   localparam logic [28:0] WEN     = 29'd1 << 4;
   localparam logic [28:0] OP_AND  = 29'd0 << 5;
   localparam logic [28:0] OP_OR   = 29'd1 << 5;
   localparam logic [28:0] OP_ADD  = 29'd2 << 5;
   localparam logic [28:0] OP_SUB  = 29'd6 << 5;
   localparam logic [28:0] REG_MUX = 29'd1 << 8;
   localparam logic [28:0] B_MUX   = 29'd1 << 9;
   localparam logic [28:0] A_MUX   = 29'd1 << 10;
   localparam logic [28:0] IM2_LZE = 29'd1 << 12;
   localparam logic [28:0] DM_MEM  = 29'd1 << 14;
   localparam logic [28:0] DM_ALU  = 29'd2 << 14;
   localparam logic [28:0] INC_PC  = 29'd1 << 16;
   localparam logic [28:0] LD_IR   = 29'd1 << 17;
   localparam logic [28:0] LD_PC   = 29'd1 << 18;
   localparam logic [28:0] LD_Z    = 29'd1 << 19;
   localparam logic [28:0] LD_C    = 29'd1 << 20;
   localparam logic [28:0] LD_B    = 29'd1 << 21;
   localparam logic [28:0] LD_A    = 29'd1 << 22;
   localparam logic [28:0] CLR_ALL = 29'h3F << 23;
   localparam logic [28:0] ALU_WB  = DM_ALU | LD_A | LD_C | LD_Z;

   logic        clk = 1'b0;
   logic        reset, run, alu_c, alu_z;
   logic [31:0] ir;
   logic        clr_A, clr_B, clr_C, clr_Z, clr_PC, clr_IR;
   logic        ld_A, ld_B, ld_C, ld_Z, ld_PC, ld_IR, inc_PC;
   logic [1:0]  data_mux, im_mux2;
   logic        im_mux1, a_mux, b_mux, reg_mux;
   logic [2:0]  alu_op;
   logic        wen, en, flag_c, flag_z, halted;

   control_unit #(.MEM_LAT(2)) dut (
      .clk(clk), .reset(reset), .run(run), .ir(ir), .alu_c(alu_c), .alu_z(alu_z),
      .clr_A(clr_A), .clr_B(clr_B), .clr_C(clr_C), .clr_Z(clr_Z), .clr_PC(clr_PC), .clr_IR(clr_IR),
      .ld_A(ld_A), .ld_B(ld_B), .ld_C(ld_C), .ld_Z(ld_Z), .ld_PC(ld_PC), .ld_IR(ld_IR),
      .inc_PC(inc_PC), .data_mux(data_mux), .im_mux2(im_mux2), .im_mux1(im_mux1),
      .a_mux(a_mux), .b_mux(b_mux), .reg_mux(reg_mux), .alu_op(alu_op),
      .wen(wen), .en(en), .flag_c(flag_c), .flag_z(flag_z), .halted(halted)
   );

   always #5 clk = ~clk;

   logic [28:0] w_obs;
   assign w_obs = {clr_A, clr_B, clr_C, clr_Z, clr_PC, clr_IR,
                   ld_A, ld_B, ld_C, ld_Z, ld_PC, ld_IR, inc_PC,
                   data_mux, im_mux2, im_mux1, a_mux, b_mux, reg_mux,
                   alu_op, wen, en, flag_c, flag_z, halted};

   typedef struct {
      string       name;
      logic [28:0] exp;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   logic [28:0] fl;

   // Monitor: every cycle that has a queued expectation is compared mid-cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (w_obs !== e.exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", e.name, w_obs, e.exp);
         end
      end
   end

   task automatic cyc(input string nm, input logic [28:0] e);
      exp_t t;
      t.name = nm;
      t.exp  = e;
      sb.push_back(t);
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input string nm, input logic [31:0] word, input logic [28:0] ex);
      ir = word;
      cyc({nm, "_fetch"}, LD_IR | fl);
      cyc({nm, "_dec"}, INC_PC | fl);
      cyc({nm, "_exec"}, ex | fl);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; run = 1'b0; ir = 32'h0; alu_c = 1'b0; alu_z = 1'b0; fl = '0;
      @(posedge clk);
      #1;
      cyc("rst_hold", CLR_ALL);
      reset = 1'b0;
      cyc("rst_clr", CLR_ALL);

      for (int i = 0; i < 4; i++) cyc("stall", fl);

      run = 1'b1;
      instr("ldai5", 32'h0000_0005, A_MUX | LD_A);
      instr("ldbi3", 32'h1000_0003, B_MUX | LD_B);
      alu_c = 1'b0; alu_z = 1'b0;
      instr("add53", 32'h6000_0000, OP_ADD | ALU_WB);
      fl = '0;

      instr("ldai0", 32'h0000_0000, A_MUX | LD_A);
      instr("ldbi0", 32'h1000_0000, B_MUX | LD_B);
      alu_c = 1'b0; alu_z = 1'b1;
      instr("add00", 32'h6000_0000, OP_ADD | ALU_WB);
      fl = F_Z;
      instr("jz_taken", 32'hC000_0010, LD_PC);

      instr("ldai0b", 32'h0000_0000, A_MUX | LD_A);
      instr("ldbi0b", 32'h1000_0000, B_MUX | LD_B);
      instr("add00b", 32'h6000_0000, OP_ADD | ALU_WB);
      fl = F_Z;
      instr("jc_not", 32'hD000_0010, 29'd0);

      alu_c = 1'b1; alu_z = 1'b0;
      instr("add_c", 32'h6000_0000, OP_ADD | ALU_WB);
      fl = F_C;
      instr("jc_taken", 32'hD000_0010, LD_PC);
      instr("jz_not", 32'hC000_0010, 29'd0);

      instr("stb", 32'h5000_0020, EN | WEN | REG_MUX);
      instr("lda", 32'h2000_0020, EN);
      cyc("lda_mem1", EN | fl);
      cyc("lda_mem2", EN | DM_MEM | LD_A | fl);
      instr("ldb", 32'h3000_0020, EN);
      cyc("ldb_mem1", EN | fl);
      cyc("ldb_mem2", EN | DM_MEM | LD_B | fl);

      alu_c = 1'b1; alu_z = 1'b1;
      instr("sub", 32'h7000_0000, OP_SUB | ALU_WB);
      fl = F_C | F_Z;
      alu_c = 1'b0; alu_z = 1'b0;
      instr("and", 32'h8000_0000, OP_AND | ALU_WB);
      fl = '0;
      alu_c = 1'b0; alu_z = 1'b1;
      instr("or", 32'h9000_0000, OP_OR | ALU_WB);
      fl = F_Z;
      alu_c = 1'b1; alu_z = 1'b0;
      instr("addi", 32'hA000_0007, OP_ADD | IM2_LZE | ALU_WB);
      fl = F_C;
      instr("sta", 32'h4000_0030, EN | WEN);
      instr("nop", 32'hE000_0000, 29'd0);
      instr("jmp", 32'hB000_0040, LD_PC);

      instr("lda_rst", 32'h2000_0020, EN);
      reset = 1'b1;
      cyc("lda_rst_mem1", EN | fl);
      reset = 1'b0;
      fl = '0;
      cyc("midmem_clr", CLR_ALL);
      run = 1'b0;
      cyc("post_rst_fetch", fl);

      run = 1'b1;
      ir = 32'hF000_0000;
      cyc("halt_fetch", LD_IR | fl);
      cyc("halt_dec", fl);
      for (int i = 0; i < 100; i++) begin
         run = 1'($urandom_range(0, 1));
         cyc("halt_hold", HALTED | fl);
      end
      reset = 1'b1;
      cyc("halt_rst_edge", HALTED);
      reset = 1'b0;
      cyc("halt_exit", CLR_ALL);

      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_drain got=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
